fc_output_drain: RTL and testbench



---
 rtl/fc_output_drain_pkg.sv | 30 +++
 rtl/fc_output_drain_requant.sv | 38 +++
 rtl/fc_output_drain.sv | 129 ++++++++++++
 tb/tb_fc_output_drain.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_output_drain_pkg.sv
// Shared types and default geometry for the FC output drain.
// Build option FC_RELU_EN (see fc_requant) clamps negative results to zero.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } fc_state_e;

  localparam int FC_TILING_SIZE = 8;
  localparam int FC_KERNEL_SIZE = 4096;
  localparam int FC_ACC_W       = 32;
  localparam int FC_DATA_W      = 16;
  localparam int FC_SHIFT       = 8;

  localparam int KADDR_W   = $clog2(FC_KERNEL_SIZE);
  localparam int NUM_TILES = FC_KERNEL_SIZE / FC_TILING_SIZE;

  // Saturation window for the default output width.
  localparam int SAT_MAX = (1 << (FC_DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (FC_DATA_W - 1));

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_output_drain_requant.sv
// Combinational requantizer: bias add, arithmetic shift, optional ReLU, saturate.
// Defining FC_RELU_EN forces negative shifted values to zero.
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_W  = FC_ACC_W,
  parameter int DATA_W = FC_DATA_W,
  parameter int SHIFT  = FC_SHIFT
) (
  input  logic [ACC_W-1:0]  i_psum,
  input  logic [ACC_W-1:0]  i_bias,
  output logic [DATA_W-1:0] o_q
);

  localparam logic signed [ACC_W:0] LIM_MAX = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] LIM_MIN = ~LIM_MAX;

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;
  logic signed [ACC_W:0] w_rect;

  // One guard bit keeps the bias add from wrapping before the shift.
  assign w_sum = $signed({i_psum[ACC_W-1], i_psum}) + $signed({i_bias[ACC_W-1], i_bias});
  assign w_shr = w_sum >>> SHIFT;

`ifdef FC_RELU_EN
  assign w_rect = w_shr[ACC_W] ? '0 : w_shr;
`else
  assign w_rect = w_shr;
`endif

  always_comb begin
    o_q = w_rect[DATA_W-1:0];
    if (w_rect > LIM_MAX)      o_q = LIM_MAX[DATA_W-1:0];
    else if (w_rect < LIM_MIN) o_q = LIM_MIN[DATA_W-1:0];
  end

endmodule

// File: rtl/fc_output_drain.sv
// Drains one captured tile of partial sums lane by lane through bias add and requant.
// ReLU behaviour is selected at build time by FC_RELU_EN.
module fc_output_drain
  import fc_pkg::*;
#(
  parameter int TILING_SIZE = FC_TILING_SIZE,
  parameter int KERNEL_SIZE = FC_KERNEL_SIZE,
  parameter int ACC_W       = FC_ACC_W,
  parameter int DATA_W      = FC_DATA_W,
  parameter int SHIFT       = FC_SHIFT
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic                           set_output,
  input  logic [TILING_SIZE*ACC_W-1:0]   psum_in,
  output logic                           bias_rd_en,
  output logic [$clog2(KERNEL_SIZE)-1:0] bias_addr,
  input  logic [ACC_W-1:0]               bias_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(KERNEL_SIZE)-1:0] out_index,
  output logic                           out_last,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           overrun
);

  localparam int KA_W   = $clog2(KERNEL_SIZE);
  localparam int NT     = KERNEL_SIZE / TILING_SIZE;
  localparam int LANE_W = cnt_w(TILING_SIZE);
  localparam int TILE_W = cnt_w(NT);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(TILING_SIZE - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NT - 1);

  fc_state_e r_state, w_state_nxt;

  logic [TILING_SIZE-1:0][ACC_W-1:0] r_psum;
  logic [LANE_W-1:0]                 r_lane;
  logic [TILE_W-1:0]                 r_tile;
  logic [KA_W-1:0]                   r_base;
  logic [DATA_W-1:0]                 r_out_data;
  logic [KA_W-1:0]                   r_out_index;
  logic                              r_frame_done;
  logic                              r_overrun;

  logic                              w_hs;
  logic                              w_last_lane;
  logic                              w_last_tile;
  logic [KA_W-1:0]                   w_idx;
  logic [DATA_W-1:0]                 w_q;

  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_last_tile = (r_tile == LAST_TILE);
  assign w_idx       = r_base + KA_W'(r_lane);
  assign w_hs        = (r_state == ST_OUT) && out_ready;

  fc_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_requant (
    .i_psum (r_psum[r_lane]),
    .i_bias (bias_data),
    .o_q    (w_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    bias_rd_en  = 1'b0;
    bias_addr   = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      ST_IDLE: if (set_output) w_state_nxt = ST_RD;
      ST_RD: begin
        bias_rd_en  = 1'b1;
        bias_addr   = w_idx;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: w_state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = w_last_lane && w_last_tile;
        if (out_ready) w_state_nxt = w_last_lane ? ST_IDLE : ST_RD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_psum       <= '0;
      r_lane       <= '0;
      r_tile       <= '0;
      r_base       <= '0;
      r_out_data   <= '0;
      r_out_index  <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_hs && w_last_lane && w_last_tile;
      if (r_state == ST_IDLE && set_output) begin
        r_psum <= psum_in;
        r_lane <= '0;
        r_base <= KA_W'(r_tile * TILING_SIZE);
      end
      // A pulse arriving while any lane is still in flight is dropped, not queued.
      if (r_state != ST_IDLE && set_output) r_overrun <= 1'b1;
      if (r_state == ST_WAIT) begin
        r_out_data  <= w_q;
        r_out_index <= w_idx;
      end
      if (w_hs) begin
        if (w_last_lane) r_tile <= w_last_tile ? '0 : r_tile + 1'b1;
        else             r_lane <= r_lane + 1'b1;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_index  = r_out_index;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_fc_output_drain.sv
// Directed bench for fc_output_drain with a 16-kernel, 8-lane layer.
module tb_fc_output_drain;

  localparam int TS = 8;
  localparam int KS = 16;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int KA = 4;

  logic            clk1 = 1'b0;
  logic            rst;
  logic            set_output;
  logic [TS*AW-1:0] psum_in;
  logic            bias_rd_en;
  logic [KA-1:0]   bias_addr;
  logic [AW-1:0]   bias_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [KA-1:0]   out_index;
  logic            out_last;
  logic            frame_done;
  logic            busy;
  logic            overrun;

  logic [AW-1:0]   bias_mem [KS];
  int n_chk  = 0;
  int n_fail = 0;

  fc_output_drain #(
    .TILING_SIZE (TS),
    .KERNEL_SIZE (KS),
    .ACC_W       (AW),
    .DATA_W      (DW),
    .SHIFT       (8)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .set_output (set_output),
    .psum_in    (psum_in),
    .bias_rd_en (bias_rd_en),
    .bias_addr  (bias_addr),
    .bias_data  (bias_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk1 = ~clk1;

  // Bias memory: one-cycle read latency.
  always @(posedge clk1) begin
    if (bias_rd_en) bias_data <= bias_mem[bias_addr];
  end

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".rd_en"},   32'(bias_rd_en), 32'd0);
    check({tag, ".addr"},    32'(bias_addr),  32'd0);
    check({tag, ".valid"},   32'(out_valid),  32'd0);
    check({tag, ".data"},    32'(out_data),   32'd0);
    check({tag, ".index"},   32'(out_index),  32'd0);
    check({tag, ".last"},    32'(out_last),   32'd0);
    check({tag, ".fdone"},   32'(frame_done), 32'd0);
    check({tag, ".busy"},    32'(busy),       32'd0);
    check({tag, ".overrun"}, 32'(overrun),    32'd0);
  endtask

  task automatic start_tile(input logic [TS*AW-1:0] p);
    psum_in    = p;
    set_output = 1'b1;
    tick();
    set_output = 1'b0;
    psum_in    = '1;
  endtask

  // Entered in RD; leaves just after the handshake edge.
  task automatic drain_lane(input int idx, input logic [DW-1:0] exp_q, input bit exp_last,
                            input int hold, input bit pulse_wait, input bit pulse_hs);
    check("rd.rd_en", 32'(bias_rd_en), 32'd1);
    check("rd.addr",  32'(bias_addr),  32'(idx));
    check("rd.valid", 32'(out_valid),  32'd0);
    tick();
    check("wait.valid", 32'(out_valid),  32'd0);
    check("wait.rd_en", 32'(bias_rd_en), 32'd0);
    if (hold > 0) out_ready = 1'b0;
    if (pulse_wait) begin
      set_output = 1'b1;
      psum_in    = {TS{32'h1234_5678}};
    end
    tick();
    set_output = 1'b0;
    check("out.valid", 32'(out_valid), 32'd1);
    check("out.data",  32'(out_data),  32'(exp_q));
    check("out.index", 32'(out_index), 32'(idx));
    check("out.last",  32'(out_last),  32'(exp_last));
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold.valid", 32'(out_valid),  32'd1);
      check("hold.data",  32'(out_data),   32'(exp_q));
      check("hold.index", 32'(out_index),  32'(idx));
      check("hold.rd_en", 32'(bias_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    if (pulse_hs) set_output = 1'b1;
    tick();
    set_output = 1'b0;
  endtask

  logic [TS*AW-1:0] p;
  logic [DW-1:0]    neg_exp;

  initial begin
    rst        = 1'b1;
    set_output = 1'b0;
    out_ready  = 1'b1;
    psum_in    = '0;
    for (int k = 0; k < KS; k++) bias_mem[k] = '0;
    bias_mem[0] = 32'h0000_0100;
    for (int i = 0; i < TS; i++) bias_mem[TS + i] = 32'(i) << 8;
`ifdef FC_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif

    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    tick();
    check_quiet("idle");

    // Tile 0: basic lane, saturation high/low, backpressure on lane 3.
    p = '0;
    p[0*AW +: AW] = 32'h0000_1000;
    p[1*AW +: AW] = 32'h7FFF_0000;
    p[2*AW +: AW] = 32'hFF00_0000;
    for (int i = 3; i < TS; i++) p[i*AW +: AW] = 32'(i) << 8;
    start_tile(p);
    drain_lane(0, 16'h0011, 1'b0, 0, 1'b0, 1'b0);
    drain_lane(1, 16'h7FFF, 1'b0, 0, 1'b0, 1'b0);
    drain_lane(2, neg_exp,  1'b0, 0, 1'b0, 1'b0);
    drain_lane(3, 16'h0003, 1'b0, 5, 1'b0, 1'b0);
    for (int i = 4; i < TS; i++) drain_lane(i, DW'(i), 1'b0, 0, 1'b0, 1'b0);
    check("t0.fdone",   32'(frame_done), 32'd0);
    check("t0.busy",    32'(busy),       32'd0);
    check("t0.overrun", 32'(overrun),    32'd0);

    // Tile 1: last tile of the layer.
    for (int i = 0; i < TS; i++) p[i*AW +: AW] = 32'h0000_1000;
    start_tile(p);
    for (int i = 0; i < TS; i++)
      drain_lane(TS + i, DW'(16'h10 + i), (i == TS - 1), 0, 1'b0, 1'b0);
    check("t1.fdone", 32'(frame_done), 32'd1);
    check("t1.busy",  32'(busy),       32'd0);
    tick();
    check("t1.fdone_end", 32'(frame_done), 32'd0);

    // Wrapped tile with an overrun pulse mid-drain and one on the final handshake.
    for (int i = 0; i < TS; i++) p[i*AW +: AW] = 32'(16'h20 + i) << 8;
    start_tile(p);
    drain_lane(0, 16'h0021, 1'b0, 0, 1'b0, 1'b0);
    drain_lane(1, 16'h0021, 1'b0, 0, 1'b1, 1'b0);
    check("ov.set", 32'(overrun), 32'd1);
    for (int i = 2; i < TS - 1; i++) drain_lane(i, DW'(16'h20 + i), 1'b0, 0, 1'b0, 1'b0);
    drain_lane(TS - 1, 16'h0027, 1'b0, 0, 1'b0, 1'b1);
    check("ov.sticky",  32'(overrun),    32'd1);
    check("ov.idle",    32'(busy),       32'd0);
    check("ov.fdone",   32'(frame_done), 32'd0);
    tick();
    check("ov.no_start", 32'(busy), 32'd0);

    // Tile counter advanced exactly once across the overrun tile.
    start_tile(p);
    check("t3.addr", 32'(bias_addr), 32'd8);
    check("t3.busy", 32'(busy),      32'd1);

    // Reset mid-drain abandons the tile and clears overrun.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("midrst");
    start_tile(p);
    check("rst.addr", 32'(bias_addr), 32'd0);
    tick();
    tick();
    check("rst.data", 32'(out_data), 32'h0021);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
